// File: rtl/coffee_brewer.sv
`default_nettype none
// ============================================================================
// Module      : coffee_brewer
// Description : Brewing unit: heat then brew on request, portion stock
//               tracking, cup hand-off. Optional cup counter under
//               BREWER_CUPCOUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module coffee_brewer #(
    parameter int HEAT_CYCLES = 8,
    parameter int BREW_CYCLES = 12,
    parameter int STOCK_MAX   = 3,
    parameter int STOCK_W     = 8
) (
    input  logic               clk11m,
    input  logic               rst_n,
    input  logic               prepare_coffee,
    input  logic               cup_sensor,
    input  logic               refill,
    output logic               coffee_ready,
    output logic               machine_empty,
    output logic               cup_out,
    output logic               heater_on,
    output logic               pump_on,
    output logic [STOCK_W-1:0] stock_level
`ifdef BREWER_CUPCOUNT_EN
    ,
    output logic [15:0]        cups_served
`endif
);

    localparam int MAX_CYC = (HEAT_CYCLES > BREW_CYCLES) ? HEAT_CYCLES : BREW_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TIMER_W-1:0] HEAT_LOAD  = TIMER_W'(HEAT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] BREW_LOAD  = TIMER_W'(BREW_CYCLES - 1);
    localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_MAX);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HEAT  = 3'd1,
        S_BREW  = 3'd2,
        S_SERVE = 3'd3,
        S_EMPTY = 3'd4
    } state_t;

    state_t             state_q,  state_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic [STOCK_W-1:0] stock_q,  stock_d;
    logic               cup_meta_q, cup_meta_d;
    logic               cup_s_q,    cup_s_d;
    logic               heater_q, heater_d;
    logic               pump_q,   pump_d;
    logic               ready_q,  ready_d;
    logic               cup_out_q, cup_out_d;
    logic               empty_q,  empty_d;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        stock_d    = stock_q;
        cup_meta_d = cup_sensor;
        cup_s_d    = cup_meta_q;

        case (state_q)
            S_IDLE: begin
                // Refill wins over a simultaneous brew request.
                if (refill) begin
                    stock_d = STOCK_FULL;
                end else if (stock_q == '0) begin
                    state_d = S_EMPTY;
                end else if (prepare_coffee && cup_s_q) begin
                    state_d = S_HEAT;
                    timer_d = HEAT_LOAD;
                end
            end
            S_HEAT: begin
                if (timer_q == '0) begin
                    state_d = S_BREW;
                    timer_d = BREW_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_BREW: begin
                if (timer_q == '0) begin
                    state_d = S_SERVE;
                    stock_d = stock_q - 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_SERVE: begin
                if (!cup_s_q) begin
                    state_d = S_IDLE;
                end
            end
            S_EMPTY: begin
                if (refill) begin
                    stock_d = STOCK_FULL;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of the next-state decode so they
        // line up with the state register without extra latency.
        heater_d  = (state_d == S_HEAT);
        pump_d    = (state_d == S_BREW);
        ready_d   = (state_d == S_SERVE);
        cup_out_d = (state_q == S_SERVE) && !cup_s_q;
        empty_d   = (stock_d == '0);
    end

    always_ff @(posedge clk11m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            stock_q    <= STOCK_FULL;
            cup_meta_q <= 1'b0;
            cup_s_q    <= 1'b0;
            heater_q   <= 1'b0;
            pump_q     <= 1'b0;
            ready_q    <= 1'b0;
            cup_out_q  <= 1'b0;
            empty_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            stock_q    <= stock_d;
            cup_meta_q <= cup_meta_d;
            cup_s_q    <= cup_s_d;
            heater_q   <= heater_d;
            pump_q     <= pump_d;
            ready_q    <= ready_d;
            cup_out_q  <= cup_out_d;
            empty_q    <= empty_d;
        end
    end

    assign heater_on     = heater_q;
    assign pump_on       = pump_q;
    assign coffee_ready  = ready_q;
    assign cup_out       = cup_out_q;
    assign machine_empty = empty_q;
    assign stock_level   = stock_q;

`ifdef BREWER_CUPCOUNT_EN
    logic [15:0] cups_served_q, cups_served_d;

    // Counts in step with the cup_out pulse and sticks at all-ones.
    always_comb begin
        cups_served_d = cups_served_q;
        if (cup_out_d && (cups_served_q != 16'hFFFF)) begin
            cups_served_d = cups_served_q + 16'd1;
        end
    end

    always_ff @(posedge clk11m or negedge rst_n) begin
        if (!rst_n) begin
            cups_served_q <= 16'd0;
        end else begin
            cups_served_q <= cups_served_d;
        end
    end

    assign cups_served = cups_served_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coffee_brewer.sv
`default_nettype none
// ============================================================================
// Module      : tb_coffee_brewer
// Description : Scoreboard bench for coffee_brewer (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coffee_brewer;

    logic       clk11m         = 1'b0;
    logic       rst_n          = 1'b0;
    logic       prepare_coffee = 1'b0;
    logic       cup_sensor     = 1'b0;
    logic       refill         = 1'b0;
    logic       coffee_ready;
    logic       machine_empty;
    logic       cup_out;
    logic       heater_on;
    logic       pump_on;
    logic [7:0] stock_level;
`ifdef BREWER_CUPCOUNT_EN
    logic [15:0] cups_served;
    int          exp_cups = 0;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       heater;
        logic       pump;
        logic       ready;
        logic       cup_out;
        logic       empty;
        logic [7:0] stock;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    exp_t sb[$];

    coffee_brewer dut (
        .clk11m         (clk11m),
        .rst_n          (rst_n),
        .prepare_coffee (prepare_coffee),
        .cup_sensor     (cup_sensor),
        .refill         (refill),
        .coffee_ready   (coffee_ready),
        .machine_empty  (machine_empty),
        .cup_out        (cup_out),
        .heater_on      (heater_on),
        .pump_on        (pump_on),
        .stock_level    (stock_level)
`ifdef BREWER_CUPCOUNT_EN
        ,
        .cups_served    (cups_served)
`endif
    );

    always #5 clk11m = ~clk11m;

    function automatic obs_t sample();
        obs_t o;
        o.heater  = heater_on;
        o.pump    = pump_on;
        o.ready   = coffee_ready;
        o.cup_out = cup_out;
        o.empty   = machine_empty;
        o.stock   = stock_level;
        return o;
    endfunction

    // Expected-value producer: n cycles of the given output vector.
    task automatic push(input int n, input bit h, input bit p, input bit r,
                        input bit c, input logic [7:0] s, input string tag);
        exp_t e;
        e.v.heater  = h;
        e.v.pump    = p;
        e.v.ready   = r;
        e.v.cup_out = c;
        e.v.empty   = (s == 8'd0);
        e.v.stock   = s;
        e.tag       = tag;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Full brew from IDLE with cup synced present, then cup removal.
    task automatic brew_and_serve(input logic [7:0] s, input int refill_at, input string name);
        obs_t o;
        exp_t e;
        prepare_coffee = 1'b1;
        push(8,  1, 0, 0, 0, s,        {name, "_heat"});
        push(12, 0, 1, 0, 0, s,        {name, "_pump"});
        push(1,  0, 0, 1, 0, s - 8'd1, {name, "_ready"});
        for (int i = 1; sb.size() > 0; i++) begin
            @(negedge clk11m);
            prepare_coffee = 1'b0;
            refill = (i == refill_at);
            o = sample();
            e = sb.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s cycle %0d: got %h expected %h", e.tag, i, o, e.v);
            end
        end
        refill     = 1'b0;
        cup_sensor = 1'b0;
        push(2, 0, 0, 1, 0, s - 8'd1, {name, "_serve_hold"});
        push(1, 0, 0, 0, 1, s - 8'd1, {name, "_cup_out"});
        push(1, 0, 0, 0, 0, s - 8'd1, {name, "_after_serve"});
        while (sb.size() > 0) begin
            @(negedge clk11m);
            o = sample();
            e = sb.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, o, e.v);
            end
        end
`ifdef BREWER_CUPCOUNT_EN
        exp_cups++;
`endif
        cup_sensor = 1'b1;
        repeat (3) @(negedge clk11m);
    endtask

    task automatic test_reset();
        obs_t o;
        exp_t e;
        push(1, 0, 0, 0, 0, 8'd3, "reset_held");
        o = sample();
        e = sb.pop_front();
        checks++;
        if (o !== e.v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.tag, o, e.v);
        end
        rst_n = 1'b1;
        push(3, 0, 0, 0, 0, 8'd3, "reset_idle");
        while (sb.size() > 0) begin
            @(negedge clk11m);
            o = sample();
            e = sb.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, o, e.v);
            end
        end
`ifdef BREWER_CUPCOUNT_EN
        checks++;
        if (cups_served !== 16'd0) begin
            failures++;
            $display("FAIL reset_cups: got %0d expected 0", cups_served);
        end
`endif
    endtask

    task automatic test_brew();
        brew_and_serve(8'd3, 0, "brew1");
`ifdef BREWER_CUPCOUNT_EN
        checks++;
        if (cups_served !== 16'(exp_cups)) begin
            failures++;
            $display("FAIL cups_after_brew1: got %0d expected %0d", cups_served, exp_cups);
        end
`endif
    endtask

    task automatic test_no_cup();
        obs_t o;
        exp_t e;
        cup_sensor = 1'b0;
        repeat (3) @(negedge clk11m);
        prepare_coffee = 1'b1;
        push(6, 0, 0, 0, 0, 8'd2, "no_cup_idle");
        while (sb.size() > 0) begin
            @(negedge clk11m);
            o = sample();
            e = sb.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, o, e.v);
            end
        end
        prepare_coffee = 1'b0;
        cup_sensor     = 1'b1;
        repeat (3) @(negedge clk11m);
    endtask

    task automatic test_refill_priority();
        obs_t o;
        exp_t e;
        prepare_coffee = 1'b1;
        refill         = 1'b1;
        push(2, 0, 0, 0, 0, 8'd3, "refill_priority");
        while (sb.size() > 0) begin
            @(negedge clk11m);
            prepare_coffee = 1'b0;
            refill         = 1'b0;
            o = sample();
            e = sb.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, o, e.v);
            end
        end
    endtask

    task automatic test_empty();
        obs_t o;
        exp_t e;
        brew_and_serve(8'd3, 0, "empty_b1");
        brew_and_serve(8'd2, 0, "empty_b2");
        brew_and_serve(8'd1, 0, "empty_b3");
        prepare_coffee = 1'b1;
        push(6, 0, 0, 0, 0, 8'd0, "empty_no_brew");
        while (sb.size() > 0) begin
            @(negedge clk11m);
            o = sample();
            e = sb.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, o, e.v);
            end
        end
        prepare_coffee = 1'b0;
        refill         = 1'b1;
        push(2, 0, 0, 0, 0, 8'd3, "empty_refill");
        while (sb.size() > 0) begin
            @(negedge clk11m);
            refill = 1'b0;
            o = sample();
            e = sb.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, o, e.v);
            end
        end
`ifdef BREWER_CUPCOUNT_EN
        checks++;
        if (cups_served !== 16'(exp_cups)) begin
            failures++;
            $display("FAIL cups_after_refill: got %0d expected %0d", cups_served, exp_cups);
        end
`endif
    endtask

    task automatic test_refill_during_brew();
        brew_and_serve(8'd3, 10, "brew_refill_ignored");
`ifdef BREWER_CUPCOUNT_EN
        checks++;
        if (cups_served !== 16'(exp_cups)) begin
            failures++;
            $display("FAIL cups_after_refill_brew: got %0d expected %0d", cups_served, exp_cups);
        end
`endif
    endtask

    task automatic test_reset_mid_brew();
        obs_t o;
        exp_t e;
        prepare_coffee = 1'b1;
        @(negedge clk11m);
        prepare_coffee = 1'b0;
        repeat (11) @(negedge clk11m);
        push(1, 0, 1, 0, 0, 8'd2, "mid_brew_pump");
        o = sample();
        e = sb.pop_front();
        checks++;
        if (o !== e.v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.tag, o, e.v);
        end
        rst_n = 1'b0;
        #1;
        push(1, 0, 0, 0, 0, 8'd3, "mid_brew_reset");
        o = sample();
        e = sb.pop_front();
        checks++;
        if (o !== e.v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.tag, o, e.v);
        end
        @(negedge clk11m);
        rst_n = 1'b1;
        push(30, 0, 0, 0, 0, 8'd3, "post_reset_idle");
        while (sb.size() > 0) begin
            @(negedge clk11m);
            o = sample();
            e = sb.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.tag, o, e.v);
            end
        end
`ifdef BREWER_CUPCOUNT_EN
        checks++;
        if (cups_served !== 16'd0) begin
            failures++;
            $display("FAIL cups_after_reset: got %0d expected 0", cups_served);
        end
`endif
    endtask

    initial begin
        cup_sensor = 1'b1;
        repeat (2) @(negedge clk11m);
        test_reset();
        test_brew();
        test_no_cup();
        test_refill_priority();
        test_empty();
        test_refill_during_brew();
        test_reset_mid_brew();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
